// File: rtl/csr_trap_ctrl_if.sv
// csr_trap_ctrl_if: pipeline, CSR-tap and CSR-write-port signals of the trap sequencer
interface csr_trap_ctrl_if;
  logic        irq_timer_i;
  logic        irq_ext_i;
  logic        instr_valid_i;
  logic [31:0] pc_i;
  logic        mret_i;
  logic [31:0] mstatus_i;
  logic [31:0] mie_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic [31:0] mip_o;
  logic        csr_wr_o;
  logic [31:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        stall_o;
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  modport master (
    output irq_timer_i, irq_ext_i, instr_valid_i, pc_i, mret_i, mstatus_i, mie_i, mtvec_i, mepc_i,
    input  mip_o, csr_wr_o, csr_waddr_o, csr_wdata_o, stall_o, flush_o, redirect_o, redirect_pc_o
  );
  modport slave (
    input  irq_timer_i, irq_ext_i, instr_valid_i, pc_i, mret_i, mstatus_i, mie_i, mtvec_i, mepc_i,
    output mip_o, csr_wr_o, csr_waddr_o, csr_wdata_o, stall_o, flush_o, redirect_o, redirect_pc_o
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: machine-mode interrupt/mret sequencer driving the CSR file write port
module csr_trap_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter bit VECTORED_EN = 1'b1
) (
  input logic           clk,
  input logic           rst,
  csr_trap_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, MRET_STATUS, REDIRECT} state_e;
  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] tim_sync_q, ext_sync_q;
  logic                   mip_tim_q, mip_ext_q;
  logic [31:0]            epc_q, epc_d, target_q, target_d;
  logic [4:0]             cause_q, cause_d;
  logic                   mret_q, mret_d;
  logic                   pend_ext, pend_tim, take_irq, take_mret;
  logic [4:0]             irq_cause;
  logic [31:0]            base, irq_target;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tim_sync_q <= '0;
      ext_sync_q <= '0;
      mip_tim_q  <= 1'b0;
      mip_ext_q  <= 1'b0;
    end else begin
      tim_sync_q[0] <= bus.irq_timer_i;
      ext_sync_q[0] <= bus.irq_ext_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        tim_sync_q[i] <= tim_sync_q[i-1];
        ext_sync_q[i] <= ext_sync_q[i-1];
      end
      mip_tim_q <= tim_sync_q[SYNC_STAGES-1];
      mip_ext_q <= ext_sync_q[SYNC_STAGES-1];
    end
  end
  assign bus.mip_o = {20'b0, mip_ext_q, 3'b0, mip_tim_q, 7'b0};
  assign pend_ext  = mip_ext_q & bus.mie_i[11];
  assign pend_tim  = mip_tim_q & bus.mie_i[7];
  assign take_irq  = (state_q == IDLE) & bus.instr_valid_i & bus.mstatus_i[3] & (pend_ext | pend_tim);
  assign take_mret = (state_q == IDLE) & bus.instr_valid_i & bus.mret_i & ~take_irq;
  assign irq_cause = pend_ext ? 5'd11 : 5'd7;
  assign base      = {bus.mtvec_i[31:2], 2'b00};
  // Mode 2'b1x is reserved and falls back to direct.
  assign irq_target = (VECTORED_EN && bus.mtvec_i[1:0] == 2'b01) ? base + {25'b0, irq_cause, 2'b00} : base;
  assign bus.flush_o = take_irq | take_mret;
  assign bus.stall_o = state_q != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      epc_q    <= '0;
      target_q <= '0;
      cause_q  <= '0;
      mret_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      target_q <= target_d;
      cause_q  <= cause_d;
      mret_q   <= mret_d;
    end
  end
  always_comb begin
    state_d           = state_q;
    epc_d             = epc_q;
    target_d          = target_q;
    cause_d           = cause_q;
    mret_d            = mret_q;
    bus.csr_wr_o      = 1'b0;
    bus.csr_waddr_o   = '0;
    bus.csr_wdata_o   = '0;
    bus.redirect_o    = 1'b0;
    bus.redirect_pc_o = '0;
    unique case (state_q)
      IDLE: begin
        if (take_irq) begin
          state_d  = SAVE_EPC;
          epc_d    = bus.pc_i;
          cause_d  = irq_cause;
          target_d = irq_target;
          mret_d   = 1'b0;
        end else if (take_mret) begin
          state_d = MRET_STATUS;
          mret_d  = 1'b1;
        end
      end
      SAVE_EPC: begin
        state_d         = SAVE_CAUSE;
        bus.csr_wr_o    = 1'b1;
        bus.csr_waddr_o = 32'h341;
        bus.csr_wdata_o = {epc_q[31:2], 2'b00};
      end
      SAVE_CAUSE: begin
        state_d         = SAVE_STATUS;
        bus.csr_wr_o    = 1'b1;
        bus.csr_waddr_o = 32'h342;
        bus.csr_wdata_o = {1'b1, 26'b0, cause_q};
      end
      SAVE_STATUS: begin
        state_d         = REDIRECT;
        bus.csr_wr_o    = 1'b1;
        bus.csr_waddr_o = 32'h300;
        bus.csr_wdata_o = bus.mstatus_i;
        bus.csr_wdata_o[7]     = bus.mstatus_i[3];
        bus.csr_wdata_o[3]     = 1'b0;
        bus.csr_wdata_o[12:11] = 2'b11;
      end
      MRET_STATUS: begin
        state_d         = REDIRECT;
        bus.csr_wr_o    = 1'b1;
        bus.csr_waddr_o = 32'h300;
        bus.csr_wdata_o = bus.mstatus_i;
        bus.csr_wdata_o[3]     = bus.mstatus_i[7];
        bus.csr_wdata_o[7]     = 1'b1;
        bus.csr_wdata_o[12:11] = 2'b11;
      end
      REDIRECT: begin
        state_d           = IDLE;
        bus.redirect_o    = 1'b1;
        bus.redirect_pc_o = mret_q ? {bus.mepc_i[31:2], 2'b00} : target_q;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb_csr_trap_ctrl: directed and randomized checks of the trap sequencer against a trace model
module tb_csr_trap_ctrl;
  localparam int SYNC = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;
  csr_trap_ctrl_if bus ();
  csr_trap_ctrl #(.SYNC_STAGES(SYNC), .VECTORED_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  function automatic logic [98:0] pk(logic st, logic wr, logic [31:0] a, logic [31:0] d, logic rd, logic [31:0] rp);
    return {st, wr, a, d, rd, rp};
  endfunction

  function automatic logic [98:0] observe();
    return pk(bus.stall_o, bus.csr_wr_o, bus.csr_waddr_o, bus.csr_wdata_o, bus.redirect_o, bus.redirect_pc_o);
  endfunction

  task automatic idle_inputs();
    bus.instr_valid_i = 1'b0;
    bus.mret_i        = 1'b0;
    bus.pc_i          = '0;
  endtask

  task automatic run_case(input string name, input logic it, input logic ie, input logic [31:0] mst,
                          input logic [31:0] mie, input logic [31:0] mtvec, input logic [31:0] mepc,
                          input logic [31:0] pc, input logic mret, input logic valid, input logic toggle);
    logic [98:0] exp_q[$];
    logic [98:0] obs;
    logic        irq_take, mret_take, pe, pt;
    logic [31:0] cause, tgt, mip_exp;
    bus.irq_timer_i = it;
    bus.irq_ext_i   = ie;
    bus.mstatus_i   = mst;
    bus.mie_i       = mie;
    bus.mtvec_i     = mtvec;
    bus.mepc_i      = mepc;
    idle_inputs();
    repeat (SYNC + 2) @(posedge clk);
    #1;
    mip_exp = (ie ? 32'd2048 : 32'd0) + (it ? 32'd128 : 32'd0);
    checks++;
    if (bus.mip_o !== mip_exp) $display("FAIL %s mip: got %h want %h", name, bus.mip_o, mip_exp);
    else passed++;
    pe        = ie && mie[11];
    pt        = it && mie[7];
    irq_take  = valid && mst[3] && (pe || pt);
    mret_take = valid && mret && !irq_take;
    cause     = pe ? 32'd11 : 32'd7;
    tgt       = (mtvec[1:0] == 2'b01) ? (mtvec & ~32'd3) + cause * 4 : mtvec & ~32'd3;
    if (irq_take) begin
      exp_q.push_back(pk(1, 1, 32'h341, pc & ~32'd3, 0, 0));
      exp_q.push_back(pk(1, 1, 32'h342, 32'h8000_0000 | cause, 0, 0));
      exp_q.push_back(pk(1, 1, 32'h300, (mst & ~32'h1888) | 32'h1800 | (mst[3] ? 32'h80 : 32'h0), 0, 0));
      exp_q.push_back(pk(1, 0, 0, 0, 1, tgt));
    end else if (mret_take) begin
      exp_q.push_back(pk(1, 1, 32'h300, (mst & ~32'h1888) | 32'h1880 | (mst[7] ? 32'h8 : 32'h0), 0, 0));
      exp_q.push_back(pk(1, 0, 0, 0, 1, mepc & ~32'd3));
    end
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
    bus.instr_valid_i = valid;
    bus.pc_i          = pc;
    bus.mret_i        = mret;
    #1;
    checks++;
    if (bus.flush_o !== (irq_take || mret_take))
      $display("FAIL %s flush: got %b want %b", name, bus.flush_o, irq_take || mret_take);
    else passed++;
    @(posedge clk);
    #1;
    idle_inputs();
    if (toggle) begin
      bus.irq_timer_i = 1'($urandom);
      bus.irq_ext_i   = 1'($urandom);
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      obs = observe();
      checks++;
      if (obs !== exp_q[k])
        $display("FAIL %s cycle T+%0d {stall,wr,addr,data,redir,pc}: got %h want %h", name, k + 1, obs, exp_q[k]);
      else passed++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [98:0] obs;
    int          bad;
    #1;
    obs = observe();
    checks++;
    if (obs !== '0 || bus.mip_o !== '0 || bus.flush_o !== 1'b0)
      $display("FAIL reset_values: got %h mip %h flush %b want all 0", obs, bus.mip_o, bus.flush_o);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.irq_timer_i = 1'b1;
    bus.mstatus_i   = 32'h8;
    bus.mie_i       = 32'h80;
    bus.mtvec_i     = 32'h100;
    repeat (SYNC + 2) @(posedge clk);
    #1;
    bus.instr_valid_i = 1'b1;
    bus.pc_i          = 32'h40;
    @(posedge clk);
    #1;
    idle_inputs();
    @(posedge clk);
    #1;
    checks++;
    if (bus.csr_wr_o !== 1'b1 || bus.csr_waddr_o !== 32'h342)
      $display("FAIL reset_pre_cause: got wr %b addr %h want 1 342", bus.csr_wr_o, bus.csr_waddr_o);
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.csr_wr_o !== 1'b0 || bus.stall_o !== 1'b0 || bus.mip_o !== '0)
      $display("FAIL reset_abort: got wr %b stall %b mip %h want 0 0 0", bus.csr_wr_o, bus.stall_o, bus.mip_o);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bad = 0;
    repeat (6) begin
      if (bus.csr_wr_o === 1'b1 || bus.stall_o !== 1'b0) bad++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (bad != 0) $display("FAIL reset_no_resume: got %0d active cycles want 0", bad);
    else passed++;
  endtask

  task automatic test_timer_direct();
    run_case("timer_direct", 1, 0, 32'h8, 32'h80, 32'h100, 32'h0, 32'h40, 0, 1, 0);
  endtask

  task automatic test_vectored();
    run_case("vectored_both", 1, 1, 32'h8, 32'h880, 32'h201, 32'h0, 32'h1000, 0, 1, 0);
    run_case("vectored_timer", 1, 0, 32'h8, 32'h880, 32'h201, 32'h0, 32'h2004, 0, 1, 0);
    run_case("mode_reserved", 0, 1, 32'h8, 32'h800, 32'h303, 32'h0, 32'h2008, 0, 1, 0);
  endtask

  task automatic test_masking();
    run_case("mask_mie_bit", 0, 1, 32'h0, 32'h800, 32'h100, 32'h0, 32'h50, 0, 1, 0);
    run_case("mask_mie_reg", 0, 1, 32'h8, 32'h80, 32'h100, 32'h0, 32'h54, 0, 1, 0);
    run_case("mask_invalid", 0, 1, 32'h8, 32'h800, 32'h100, 32'h0, 32'h58, 0, 0, 0);
  endtask

  task automatic test_mret();
    run_case("mret", 0, 0, 32'h1880, 32'h0, 32'h100, 32'h44, 32'h80, 1, 1, 0);
  endtask

  task automatic test_simultaneous();
    run_case("irq_beats_mret", 1, 0, 32'h1888, 32'h80, 32'h100, 32'h44, 32'h88, 1, 1, 1);
  endtask

  task automatic test_random();
    logic [31:0] mst, mie;
    for (int n = 0; n < 40; n++) begin
      mst    = $urandom;
      mst[3] = ($urandom_range(3) != 0);
      mie    = $urandom & ~32'h880;
      mie    = mie | ($urandom_range(1) ? 32'h80 : 0) | ($urandom_range(1) ? 32'h800 : 0);
      run_case("random", 1'($urandom), 1'($urandom), mst, mie, $urandom, $urandom, $urandom,
               1'($urandom), ($urandom_range(3) != 0), 1'b1);
    end
  endtask

  initial begin
    bus.irq_timer_i = 1'b0;
    bus.irq_ext_i   = 1'b0;
    bus.mstatus_i   = '0;
    bus.mie_i       = '0;
    bus.mtvec_i     = '0;
    bus.mepc_i      = '0;
    idle_inputs();
    test_reset();
    test_timer_direct();
    test_vectored();
    test_masking();
    test_mret();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
